// File: rtl/dma_arb5.sv
// Five-way round-robin arbiter for the DMA internal data bus: one-hot grant held
// per transfer, optional hold limit forcing rotation, and the granted client's word muxed onto O.
module dma_arb5 #(
  parameter int MAX_HOLD = 16,
  parameter int DW       = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic [4:0]    req,
  input  logic [DW-1:0] I0,
  input  logic [DW-1:0] I1,
  input  logic [DW-1:0] I2,
  input  logic [DW-1:0] I3,
  input  logic [DW-1:0] I4,
  output logic [4:0]    gnt,
  output logic [2:0]    own,
  output logic          busy,
  output logic [DW-1:0] O
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HMAX = CW'(MAX_HOLD);
  // With the limit disabled the counter just parks at 1; it never gates release.
  localparam logic [CW-1:0] HSAT = (MAX_HOLD == 0) ? CW'(1) : CW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr, ptr_d;
  logic [2:0]    own_d;
  logic [4:0]    gnt_d;
  logic [CW-1:0] hold_cnt, hold_d;

  logic [2:0] win;
  logic       found;
  logic [2:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 5; k++) begin
      idx = 3'((int'(ptr) + k) % 5);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    own_d   = own;
    ptr_d   = ptr;
    hold_d  = hold_cnt;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          own_d   = win;
          gnt_d   = 5'(5'b00001 << win);
          hold_d  = CW'(1);
        end
      end
      GRANT: begin
        if (!req[own] || (MAX_HOLD != 0 && hold_cnt == HMAX)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = own;
        end else if (hold_cnt != HSAT) begin
          hold_d = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      gnt      <= '0;
      own      <= '0;
      ptr      <= 3'd4;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      own      <= own_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
    end
  end

  assign busy = |gnt;

  always_comb begin
    O = '0;
    if (busy) begin
      case (own)
        3'd0:    O = I0;
        3'd1:    O = I1;
        3'd2:    O = I2;
        3'd3:    O = I3;
        3'd4:    O = I4;
        default: O = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_arb5.sv
// Scoreboard bench for dma_arb5: directed request vectors push hand-derived grants into a
// queue; a negedge monitor pops and compares against one of two instances (hold limit 16 and 4).
module tb_dma_arb5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req_a = '0, req_b = '0;
  logic [31:0] i0 = 32'hDEADBEEF, i1 = 32'h11111111, i2 = 32'h22222222;
  logic [31:0] i3 = 32'h33333333, i4 = 32'h44444444;
  logic [4:0]  gnt_a, gnt_b;
  logic [2:0]  own_a, own_b;
  logic        busy_a, busy_b;
  logic [31:0] o_a, o_b;

  always #5 clk = ~clk;

  dma_arb5 #(.MAX_HOLD(16), .DW(32)) dut_a (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req(req_a),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3), .I4(i4),
    .gnt(gnt_a), .own(own_a), .busy(busy_a), .O(o_a));

  dma_arb5 #(.MAX_HOLD(4), .DW(32)) dut_b (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req(req_b),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3), .I4(i4),
    .gnt(gnt_b), .own(own_b), .busy(busy_b), .O(o_b));

  typedef struct {
    int          cyc;
    bit          sel;
    logic [4:0]  g;
    logic [2:0]  o;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   active = 1'b0;
  logic [2:0] last_own [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh_idx(input logic [4:0] g);
    int r = 0;
    for (int k = 0; k < 5; k++) if (g[k]) r = k;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input int k);
    case (k)
      0: return 32'hDEADBEEF;
      1: return 32'h11111111;
      2: return 32'h22222222;
      3: return 32'h33333333;
      default: return 32'h44444444;
    endcase
  endfunction

  // Apply req to the active instance, expect eg after the coming edge, then advance.
  task automatic drive(input logic [4:0] r, input logic [4:0] eg);
    exp_t e;
    if (active) req_b = r; else req_a = r;
    e.cyc = cyc + 1;
    e.sel = active;
    e.g   = eg;
    if (eg != 5'b0) last_own[active] = 3'(oh_idx(eg));
    e.o    = last_own[active];
    e.data = (eg != 5'b0) ? word_of(oh_idx(eg)) : 32'h0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name, input logic [4:0] g, input logic [2:0] o,
                             input logic b, input logic [31:0] d);
    n_cmp++;
    if (g !== 5'b0 || o !== 3'd0 || b !== 1'b0 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL %s: gnt=%b own=%0d busy=%b O=%h, required all zero", name, g, o, b, d);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0]  g;
    logic [2:0]  o;
    logic        b;
    logic [31:0] d;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      g = e.sel ? gnt_b : gnt_a;
      o = e.sel ? own_b : own_a;
      b = e.sel ? busy_b : busy_a;
      d = e.sel ? o_b : o_a;
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL stale_entry: cycle %0d checked at %0d", e.cyc, cyc);
      end else if (g !== e.g || o !== e.o || b !== (|e.g) || d !== e.data) begin
        n_bad++;
        $display("FAIL cyc%0d dut%0d: gnt=%b own=%0d busy=%b O=%h, required gnt=%b own=%0d busy=%b O=%h",
                 cyc, e.sel, g, o, b, d, e.g, e.o, |e.g, e.data);
      end
    end
  end

  initial begin
    last_own[0] = 3'd0;
    last_own[1] = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_a", gnt_a, own_a, busy_a, o_a);
    check_reset("reset_b", gnt_b, own_b, busy_b, o_b);
    rst_n = 1'b1;

    // Reset mid-grant on the MAX_HOLD=16 instance
    active = 1'b0;
    repeat (3) drive(5'b00100, 5'b00100);
    #6;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset_a", gnt_a, own_a, busy_a, o_a);
    check_reset("async_reset_b", gnt_b, own_b, busy_b, o_b);
    last_own[0] = 3'd0;
    last_own[1] = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(5'b00100, 5'b00100);
    drive(5'b00000, 5'b00000);
    drive(5'b00000, 5'b00000);

    // Single requester
    repeat (5) drive(5'b00001, 5'b00001);
    drive(5'b00000, 5'b00000);
    drive(5'b00000, 5'b00000);

    // Client 4 takes the bus, then wrap-around to 0 and back to 4
    drive(5'b10000, 5'b10000);
    drive(5'b10000, 5'b10000);
    drive(5'b00000, 5'b00000);
    drive(5'b10001, 5'b00001);
    drive(5'b10001, 5'b00001);
    drive(5'b10000, 5'b00000);
    drive(5'b10001, 5'b10000);
    drive(5'b10001, 5'b10000);
    drive(5'b00000, 5'b00000);

    // Round-robin fairness starting from ptr=4
    for (int k = 0; k < 6; k++) begin
      logic [4:0] oh;
      oh = 5'(5'b00001 << (k % 5));
      drive(5'b11111, oh);
      drive(5'b11111, oh);
      drive(5'b11111 & ~oh, 5'b00000);
    end
    drive(5'b00000, 5'b00000);

    // Late request from client 3 during client 1's grant
    drive(5'b00010, 5'b00010);
    drive(5'b01010, 5'b00010);
    drive(5'b01010, 5'b00010);
    drive(5'b00010, 5'b00010);
    drive(5'b00000, 5'b00000);
    drive(5'b00000, 5'b00000);

    // Forced rotation on the MAX_HOLD=4 instance
    active = 1'b1;
    repeat (4) drive(5'b01010, 5'b00010);
    drive(5'b01010, 5'b00000);
    repeat (4) drive(5'b01010, 5'b01000);
    drive(5'b01010, 5'b00000);
    drive(5'b01010, 5'b00010);
    drive(5'b01010, 5'b00010);
    drive(5'b00000, 5'b00000);
    drive(5'b00000, 5'b00000);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #6;
    n_cmp++;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_arb5.md
# dma_arb5

Five-way round-robin bus arbiter with 32-bit source mux for the DMA engine's shared internal data bus. Collects requests from the five DMA clients, issues a one-hot grant that is held for a whole transfer, and selects the granted client's 32-bit word onto the shared bus. Sits directly upstream of the grant-steered fan-out stage: its `gnt` and `O` outputs drive that stage's `gnt` and `I` inputs.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive granted cycles per ownership. At this limit rotation is forced. 0 disables the limit.
- `DW`, default 32: data width.

- `wb_clk_i`  in  1  clock; all state changes on the rising edge
- `wb_rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  5  request per client; held high for the whole transfer, dropped to release
- `I0`..`I4`  in  DW each  client data words
- `gnt`  out  5  one-hot grant (registered); all-zero when idle
- `own`  out  3  index of the current or last owner (registered), 0..4
- `busy`  out  1  high while `gnt` is non-zero
- `O`  out  DW  shared bus data: `I[own]` while granted, else 0 (combinational from registered `own`/`busy`)

## Operation
- Two states:
  - IDLE: `gnt`=0.
  - GRANT: exactly one `gnt` bit set.
- Pointer `ptr` (3 bits, range 0..4) holds the last owner.
  - Search order is `ptr+1`, `ptr+2`, … mod 5.
  - The first set `req` bit in that order wins.
- IDLE:
  - Arbitrate every cycle.
  - If any `req` is set: go to GRANT, set `own`=winner, `gnt`=1<<winner, `hold_cnt`=1.
  - Otherwise stay in IDLE.
- GRANT, owner still requesting:
  - Stay in GRANT while `req[own]`=1 and the hold limit is not reached (`MAX_HOLD`=0, or `hold_cnt`<`MAX_HOLD`).
  - `hold_cnt` increments each cycle and saturates at `MAX_HOLD`.
- GRANT, release: when `req[own]`=0, or `hold_cnt`==`MAX_HOLD` with `MAX_HOLD`≠0:
  - Go to IDLE and clear `gnt`.
  - Set `ptr`=`own`.
  - `own` keeps its value.
- A forced-out owner that keeps `req` high stays eligible, but at lowest priority.
- Requests from non-owners during GRANT are ignored. They are evaluated in the next IDLE cycle.
- `req` bits are never latched; a request dropped before arbitration is lost.
- Reset (asynchronous, any state): state=IDLE, `gnt`=0, `busy`=0, `own`=0, `ptr`=4 (so client 0 has first priority), `hold_cnt`=0, hence `O`=0.
  - After reset, the first arbitration happens on the first rising edge where `wb_rst_n` is high.

## Timing
- Grant latency: `req` sampled high at edge k (in IDLE) gives `gnt` high after edge k.
- Release:
  - `req[own]` sampled low at edge m gives `gnt`=0 after edge m.
  - The earliest new grant is after edge m+1.
  - This guarantees at least one dead cycle between owners, and between back-to-back grants to the same client.
- Forced rotation: with `req` held and `MAX_HOLD`=N, `gnt` is high for exactly N cycles, then low for exactly 1 cycle.
- `O` follows `I[own]` in the same cycle. No pipeline delay from the `Ix` inputs.
- `busy` equals `|gnt` in every cycle.

## Test plan
- Reset mid-grant:
  - Stimulus: `MAX_HOLD`=16, `req`=5'b00100, wait 3 cycles into GRANT, then pulse `wb_rst_n` low.
  - Response: `gnt`, `busy`, `own` and `O` go to 0 asynchronously, before the next edge.
  - After release with `req` still 5'b00100: `gnt`=5'b00100 one edge later.
- Single requester:
  - Stimulus: `req`=5'b00001 for 5 cycles, `I0`=32'hDEADBEEF.
  - Response: `gnt`=5'b00001 for 5 cycles, starting one edge after `req` rises; `O`=32'hDEADBEEF while granted, 0 otherwise.
- Round-robin fairness:
  - Stimulus: `req`=5'b11111; each owner drops its `req` bit for 1 cycle after 2 granted cycles, then re-raises it.
  - Response: owner sequence 0,1,2,3,4,0; each grant is 2 cycles; `gnt`=0 for 1 cycle between grants.
- Forced rotation:
  - Stimulus: `MAX_HOLD`=4, `req`=5'b01010 held high.
  - Response: `gnt` 5'b00010 ×4, 0 ×1, 5'b01000 ×4, 0 ×1, 5'b00010 ….
- Wrap-around:
  - Stimulus: after client 4 releases, `req`=5'b10001.
  - Response: `gnt`=5'b00001 (client 0 wins over 4).
  - Next arbitration with `req`=5'b10001: `gnt`=5'b10000.
- Late request:
  - Stimulus: during client 1's grant, `req[3]` pulses for 2 cycles and drops before client 1 releases.
  - Response: client 3 is never granted; after the release, `gnt`=0.
